dmem_copy_engine: RTL
=====================

# dmem_copy_engine

Word-copy initiator for the data memory. It drives the memory's Address, WriteData and MemWrite inputs and samples its combinational MemData output. Given a start pulse, it copies Length consecutive words from SrcAddr to DstAddr, one read and one write per word. It sits between the control datapath and the data memory. Control is multiplexed onto the memory port only while Busy is high; that mux is outside this block.

## Interface
Parameters:
- ADDRESS_WIDTH, default 16: memory word-address width; must match the memory instance.
- DATA_WIDTH, default 32: memory word width.
- LEN_WIDTH, default 16: width of the transfer length.

Ports:
- Clk, input, 1: single clock; all state changes on posedge.
- Reset, input, 1: synchronous, active-high reset, sampled on posedge Clk.
- Start, input, 1: request pulse; sampled only in IDLE.
- SrcAddr, input, ADDRESS_WIDTH: first source word address; latched on accepted Start.
- DstAddr, input, ADDRESS_WIDTH: first destination word address; latched on accepted Start.
- Length, input, LEN_WIDTH: number of words to copy; latched on accepted Start.
- Busy, output, 1: high in READ, WRITE and DONE.
- Done, output, 1: one-cycle completion pulse.
- Address, output, ADDRESS_WIDTH: memory word address.
- WriteData, output, DATA_WIDTH: memory write data.
- MemWrite, output, 1: memory write enable.
- MemData, input, DATA_WIDTH: memory read data; combinational from Address.

## Operation
States are IDLE, READ, WRITE and DONE. The FSM is Moore: all outputs decode from registered state and registers only.

- **IDLE**: on Start, latch SrcAddr, DstAddr and Length into SrcPtr, DstPtr and Remaining.
  - If Length is 0, go to DONE.
  - Otherwise go to READ.
- **READ**: Address = SrcPtr, MemWrite = 0. At the edge, capture MemData into DataReg, then go to WRITE.
- **WRITE**: Address = DstPtr, WriteData = DataReg, MemWrite = 1. At the edge:
  - SrcPtr and DstPtr each increment by 1.
  - Remaining decrements by 1.
  - If the decremented Remaining is 0, go to DONE; otherwise go to READ.
- **DONE**: Done = 1 for exactly one cycle, then go to IDLE.

Rules and boundary conditions:
- Pointer arithmetic is modulo 2^ADDRESS_WIDTH, so the pointers wrap from all-ones to 0 with no error.
- Start in READ, WRITE or DONE is ignored. It is not queued.
- Overlapping regions use strict forward copy: word i is written before word i+1 is read. If DstAddr is in (SrcAddr, SrcAddr+Length), earlier written words propagate forward; this is the defined behaviour.
- In IDLE and DONE, Address = 0 and MemWrite = 0. WriteData equals DataReg in every state.
- Reset values: state IDLE, Busy 0, Done 0, MemWrite 0, Address 0, WriteData 0, DataReg 0, pointers 0, Remaining 0.
- Reset mid-transfer aborts. From the next cycle MemWrite is 0, with no further writes and no Done pulse. Words already written stay written.

## Timing
- Start is sampled high at edge 0 in IDLE. For N > 0, cycle numbering is:
  - Word i is read in cycle 2i+1 and written in cycle 2i+2 (i = 0..N-1).
  - Done is high in cycle 2N+1.
  - The FSM is back in IDLE in cycle 2N+2.
- For N = 0, Done is high in cycle 1 and no memory access occurs.
- The earliest next accepted Start is the edge ending cycle 2N+2, so back-to-back transfers have 2N+2 cycles of spacing.
- The memory commits its write on the edge ending a WRITE cycle. The next READ of the same address therefore sees the new data.
- MemData must settle within the READ cycle; this block adds no wait states.

## Configuration
- Macro: DMEM_COPY_CHECKSUM_EN.
- Defined: the block adds an output Checksum, DATA_WIDTH wide. It is cleared on accepted Start and on Reset. In each WRITE cycle it is updated as Checksum + DataReg, modulo 2^DATA_WIDTH. The value is stable from the DONE cycle until the next accepted Start.
- Undefined: the Checksum port and its adder do not exist. All other behaviour is identical.

## Structure
- Shared package dmem_copy_pkg holds:
  - the state enumeration (IDLE, READ, WRITE, DONE);
  - default width constants ADDRESS_WIDTH, DATA_WIDTH and LEN_WIDTH.
- One natural sub-module is dmem_copy_csum, the checksum accumulator. It is instantiated only under DMEM_COPY_CHECKSUM_EN.
- The FSM, pointers and counter stay in the top module.

## Test plan
- **Reset:** assert Reset for 2 cycles -> Busy, Done, MemWrite, Address and WriteData are all 0.
- **Basic copy:** preload mem[0..3] = 0x11, 0x22, 0x33, 0x44; Start with SrcAddr 0, DstAddr 8, Length 4 -> mem[8..11] match the source, MemWrite is high in cycles 2, 4, 6 and 8, and Done is high only in cycle 9. With DMEM_COPY_CHECKSUM_EN, Checksum = 0xAA.
- **Zero length:** Start with Length 0 -> no MemWrite, and Done is high in cycle 1.
- **Wrap-around:** SrcAddr 0xFFFF, DstAddr 0x0010, Length 2 -> reads go to 0xFFFF then 0x0000; writes go to 0x0010 and 0x0011.
- **Start while busy:** a 3-word transfer plus Start with different addresses in cycle 3 -> the second request is ignored, and exactly 3 writes occur.
- **Overlap and reset abort:** mem[0] = 0x5, Start with SrcAddr 0, DstAddr 1, Length 3 -> mem[1..3] all become 0x5. Separately, Reset in cycle 3 of a 4-word copy -> only mem[dst+0] is written, with no Done and MemWrite 0 from cycle 4.

Source files
------------

// File: rtl/dmem_copy_pkg.sv
// Shared types and default widths for the data-memory word-copy engine.
package dmem_copy_pkg;

  localparam int ADDRESS_WIDTH = 16;
  localparam int DATA_WIDTH    = 32;
  localparam int LEN_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Data-memory port as seen by the copy engine (master) and the memory (slave).
interface dmem_copy_engine_if
  import dmem_copy_pkg::*;
#(
  parameter int ADDRESS_WIDTH = dmem_copy_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = dmem_copy_pkg::DATA_WIDTH
);

  logic [ADDRESS_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0]    WriteData;
  logic                     MemWrite;
  logic [DATA_WIDTH-1:0]    MemData;

  modport master (
    output Address,
    output WriteData,
    output MemWrite,
    input  MemData
  );

  modport slave (
    input  Address,
    input  WriteData,
    input  MemWrite,
    output MemData
  );

endinterface

// File: rtl/dmem_copy_csum.sv
// Running modular sum of the words written during one copy; cleared when a copy starts.
module dmem_copy_csum
  import dmem_copy_pkg::*;
#(
  parameter int DATA_WIDTH = dmem_copy_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/dmem_copy_engine.sv
// Copies Length words from SrcAddr to DstAddr, one READ and one WRITE cycle per word.
// Optional Checksum output is built when DMEM_COPY_CHECKSUM_EN is defined.
module dmem_copy_engine
  import dmem_copy_pkg::*;
#(
  parameter int ADDRESS_WIDTH = dmem_copy_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = dmem_copy_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH     = dmem_copy_pkg::LEN_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [ADDRESS_WIDTH-1:0] SrcAddr,
  input  logic [ADDRESS_WIDTH-1:0] DstAddr,
  input  logic [LEN_WIDTH-1:0]     Length,
  output logic                     Busy,
  output logic                     Done,
`ifdef DMEM_COPY_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]    Checksum,
`endif
  dmem_copy_engine_if.master       mem
);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] src_q, src_d;
  logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          rem_d   = Length;
          state_d = (Length == '0) ? DONE : READ;
        end
      end
      READ: begin
        data_d  = mem.MemData;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + ADDRESS_WIDTH'(1);
        dst_d   = dst_q + ADDRESS_WIDTH'(1);
        rem_d   = rem_q - LEN_WIDTH'(1);
        state_d = (rem_q == LEN_WIDTH'(1)) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: decoded only from registered state and registers.
  always_comb begin
    Busy          = (state_q != IDLE);
    Done          = (state_q == DONE);
    mem.MemWrite  = (state_q == WRITE);
    mem.WriteData = data_q;
    mem.Address   = '0;
    if (state_q == READ) begin
      mem.Address = src_q;
    end else if (state_q == WRITE) begin
      mem.Address = dst_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the data register is reset as well, so WriteData is a known 0 straight out of reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

`ifdef DMEM_COPY_CHECKSUM_EN
  logic csum_clear;
  logic csum_en;

  assign csum_clear = (state_q == IDLE) && Start;
  assign csum_en    = (state_q == WRITE);

  dmem_copy_csum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_csum (
    .clk   (Clk),
    .reset (Reset),
    .clear (csum_clear),
    .en    (csum_en),
    .data  (data_q),
    .sum   (Checksum)
  );
`endif

endmodule
